// File: rtl/cpu_run_ctrl_pkg.sv
// Shared run-control definitions: FSM state encoding and stop_cause codes,
// visible to the monitor side so it can decode why a run ended.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } run_state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_QUIT = 2'd1;
    localparam logic [1:0] CAUSE_HALT = 2'd2;

    // A monitor quit outranks a halt retired in the same cycle.
    function automatic logic [1:0] stop_cause_of(input logic quit, input logic halt);
        return quit ? CAUSE_QUIT : (halt ? CAUSE_HALT : CAUSE_NONE);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset, clear and enable.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller between the UART monitor and the core: loads the start PC,
// enables execution, drains the pipeline on quit/halt and reports the stop.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_start,
    input  logic             quit_cmd,
    input  logic [29:0]      start_adr,
    input  logic             cpu_halt,
    input  logic             pipe_idle,
    input  logic [31:0]      pc_data,
    output logic             cpu_run,
    output logic             pc_load,
    output logic [29:0]      pc_load_adr,
    output logic             mon_ram_sel,
    output logic             stop_done,
    output logic [1:0]       stop_cause,
    output logic [31:0]      stop_pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       dbg_state
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    run_state_t         state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               cnt_clr;
    logic               cnt_en;

    assign dbg_state = state;
    assign cnt_clr   = (state == ST_IDLE) && cpu_start;
    assign cnt_en    = (state == ST_RUN);

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cycle_cnt)
    );

    // cpu_start/quit_cmd are single-cycle requests taken only in the state that
    // acts on them; pc_load and stop_done are single-cycle pulses with no ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cpu_run     <= 1'b0;
            pc_load     <= 1'b0;
            pc_load_adr <= '0;
            mon_ram_sel <= 1'b1;
            stop_done   <= 1'b0;
            stop_cause  <= CAUSE_NONE;
            stop_pc     <= '0;
            drain_cnt   <= '0;
        end else begin
            pc_load   <= 1'b0;
            stop_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_start) begin
                        state       <= ST_LOAD;
                        pc_load     <= 1'b1;
                        pc_load_adr <= start_adr;
                        mon_ram_sel <= 1'b0;
                        stop_cause  <= CAUSE_NONE;
                    end
                end
                ST_LOAD: begin
                    state   <= ST_RUN;
                    cpu_run <= 1'b1;
                end
                ST_RUN: begin
                    if (quit_cmd || cpu_halt) begin
                        state      <= ST_DRAIN;
                        cpu_run    <= 1'b0;
                        stop_cause <= stop_cause_of(quit_cmd, cpu_halt);
                        drain_cnt  <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // Minimum drain time first, then wait for the core to empty.
                    if ((drain_cnt == '0) && pipe_idle) begin
                        state       <= ST_IDLE;
                        stop_done   <= 1'b1;
                        stop_pc     <= pc_data;
                        mon_ram_sel <= 1'b1;
                    end else if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
